usb_utmi_tx_packet: RTL



---
 rtl/usb_utmi_tx_packet.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/usb_utmi_tx_packet.sv
// Transmit-side USB packet builder for the UTMI link.
// Accepts one token/data/handshake request at a time, forms the PID byte plus
// token+CRC5 or payload+CRC16, and streams bytes under the txvalid/txready handshake.
module usb_utmi_tx_packet #(
   parameter int unsigned MAX_LEN = 1023
) (
   input  logic        clk60,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  req_pid_i,
   input  logic [10:0] req_token_i,
   input  logic [10:0] req_len_i,
   input  logic [7:0]  data_i,
   input  logic        data_valid_i,
   output logic        data_accept_o,
   output logic        done_o,
   output logic        err_o,
   output logic [7:0]  utmi_data_out_o,
   output logic        utmi_txvalid_o,
   input  logic        utmi_txready_i
);

   typedef enum logic [3:0] {
      StIdle, StPid, StTok0, StTok1, StData, StCrcLo, StCrcHi, StDone, StErr
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  pid_q, pid_d;
   logic [10:0] token_q, token_d;
   logic [10:0] len_q, len_d;
   logic [10:0] cnt_q, cnt_d;     // index of the payload byte currently presented
   logic [7:0]  hold_q, hold_d;   // holding register; it is also the byte on the bus in StData
   logic        hold_full_q, hold_full_d;
   logic [15:0] crc_q, crc_d;     // un-inverted running CRC16
   logic [4:0]  crc5;
   logic        is_data;

   // Reflected-register form (0x14 = 0x05 reversed) so bit 0 is the first bit on the wire.
   function automatic logic [4:0] crc5_calc(input logic [10:0] tok);
      logic [4:0] c;
      c = 5'h1F;
      for (int i = 0; i < 11; i++) begin
         c = (c[0] ^ tok[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
      end
      return ~c;
   endfunction

   // Reflected-register form (0xA001 = 0x8005 reversed); crc[7:0] goes out first.
   function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   assign crc5        = crc5_calc(token_q);
   assign is_data     = (pid_q[1:0] == 2'b11);
   assign req_ready_o = (state_q == StIdle);
   assign done_o      = (state_q == StDone);
   assign err_o       = (state_q == StErr);

   // State and datapath registers
   always_ff @(posedge clk60 or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         pid_q       <= 4'h0;
         token_q     <= 11'h000;
         len_q       <= 11'h000;
         cnt_q       <= 11'h000;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         crc_q       <= 16'h0000;
      end else begin
         state_q     <= state_d;
         pid_q       <= pid_d;
         token_q     <= token_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         crc_q       <= crc_d;
      end
   end

   // Next-state, payload prefetch and UTMI byte selection
   always_comb begin
      state_d         = state_q;
      pid_d           = pid_q;
      token_d         = token_q;
      len_d           = len_q;
      cnt_d           = cnt_q;
      hold_d          = hold_q;
      hold_full_d     = hold_full_q;
      crc_d           = crc_q;
      data_accept_o   = 1'b0;
      utmi_txvalid_o  = 1'b0;
      utmi_data_out_o = 8'h00;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               pid_d       = req_pid_i;
               token_d     = req_token_i;
               len_d       = req_len_i;
               cnt_d       = 11'h000;
               hold_full_d = 1'b0;
               crc_d       = 16'hFFFF;
               if (req_pid_i[1:0] == 2'b00 ||
                   (req_pid_i[1:0] == 2'b11 && 32'(req_len_i) > MAX_LEN)) begin
                  state_d = StErr;
               end else begin
                  state_d = StPid;
               end
            end
         end
         StPid: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = {~pid_q, pid_q};
            // Fill the holding register while the PID is on the bus; a byte arriving
            // in the same cycle the PID is accepted still counts as in time.
            if (is_data && len_q != 11'h000 && !hold_full_q && data_valid_i) begin
               data_accept_o = 1'b1;
               hold_d        = data_i;
               hold_full_d   = 1'b1;
            end
            if (utmi_txready_i) begin
               unique case (pid_q[1:0])
                  2'b01:   state_d = StTok0;
                  2'b10:   state_d = StDone;
                  default: begin
                     if (len_q == 11'h000) begin
                        state_d = StCrcLo;
                     end else if (hold_full_q || data_valid_i) begin
                        state_d = StData;
                     end else begin
                        state_d = StErr;
                     end
                  end
               endcase
            end
         end
         StTok0: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = token_q[7:0];
            if (utmi_txready_i) state_d = StTok1;
         end
         StTok1: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = {crc5, token_q[10:8]};
            if (utmi_txready_i) state_d = StDone;
         end
         StData: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = hold_q;
            if (utmi_txready_i) begin
               crc_d = crc16_upd(crc_q, hold_q);
               if (cnt_q == len_q - 11'd1) begin
                  state_d     = StCrcLo;
                  hold_full_d = 1'b0;
               end else if (data_valid_i) begin
                  data_accept_o = 1'b1;
                  hold_d        = data_i;
                  cnt_d         = cnt_q + 11'd1;
               end else begin
                  // Underrun: nothing to present next cycle, abandon the packet.
                  state_d     = StErr;
                  hold_full_d = 1'b0;
               end
            end
         end
         StCrcLo: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = ~crc_q[7:0];
            if (utmi_txready_i) state_d = StCrcHi;
         end
         StCrcHi: begin
            utmi_txvalid_o  = 1'b1;
            utmi_data_out_o = ~crc_q[15:8];
            if (utmi_txready_i) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

endmodule
